// File: rtl/instr_prefetch.sv
// Instruction prefetch: streams program memory words into a small FIFO and
// hands them to the core over valid/ready, flagging the last word.
module instr_prefetch #(
  parameter int D_WIDTH  = 32,
  parameter int SA_WIDTH = 4,
  parameter int DEPTH    = 4
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Start,
  input  logic [SA_WIDTH:0]   Prog_Len,
  input  logic                Flush,
  output logic [SA_WIDTH-1:0] Addr,
  output logic                RW,
  output logic                En,
  input  logic [D_WIDTH-1:0]  Data,
  output logic [D_WIDTH-1:0]  Instr,
  output logic                Instr_Valid,
  input  logic                Instr_Ready,
  output logic                Instr_Last,
  output logic                Busy,
  output logic                Done
);
  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = PW + 2;
  localparam int STAGES = 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t state, state_nx;

  logic [SA_WIDTH:0]  len, fetch_cnt, issue_idx, len_cur;
  logic [STAGES:0]    vld_pipe, lst_pipe;
  logic [D_WIDTH-1:0] fifo [DEPTH];
  logic [DEPTH-1:0]   last_q;
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count, pend;
  logic start_acc, issue, is_last, push, pop, done_nx, busy_nx, head_last;

  assign RW          = 1'b0;
  assign En          = vld_pipe[0];
  assign Instr       = fifo[rd_ptr];
  assign Instr_Valid = (count != '0);
  assign head_last   = last_q[rd_ptr];
  assign Instr_Last  = Instr_Valid & head_last;
  assign pop         = Instr_Valid & Instr_Ready;
  assign push        = vld_pipe[STAGES] & ~Flush;

  // Credit: buffered words plus both read stages still owed by memory
  assign pend      = count + CW'(vld_pipe[0]) + CW'(vld_pipe[1]);
  assign start_acc = Start & ~Busy & (state == IDLE);
  assign len_cur   = (state == IDLE) ? Prog_Len : len;
  assign issue_idx = (state == IDLE) ? '0 : fetch_cnt;
  assign is_last   = (issue_idx == len_cur - 1'b1);

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    done_nx  = 1'b0;
    busy_nx  = Busy;
    case (state)
      IDLE: begin
        busy_nx = 1'b0;
        if (start_acc) begin
          if (Prog_Len == '0) begin
            done_nx = 1'b1;
          end else begin
            issue    = 1'b1;
            busy_nx  = 1'b1;
            state_nx = is_last ? DRAIN : FETCH;
          end
        end
      end
      FETCH: begin
        if (pend < CW'(DEPTH)) begin
          issue = 1'b1;
          if (is_last) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        // Popping the last-tagged head implies FIFO and read pipe are empty
        if (pop && head_last) begin
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (Flush) begin
      state_nx = IDLE;
      issue    = 1'b0;
      done_nx  = 1'b0;
      busy_nx  = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      len       <= '0;
      fetch_cnt <= '0;
      Addr      <= '0;
      vld_pipe  <= '0;
      lst_pipe  <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      state <= state_nx;
      Busy  <= busy_nx;
      Done  <= done_nx;
      if (start_acc) len <= Prog_Len;
      if (issue) begin
        Addr      <= issue_idx[SA_WIDTH-1:0];
        fetch_cnt <= issue_idx + 1'b1;
      end
      if (Flush) begin
        vld_pipe <= '0;
        lst_pipe <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        vld_pipe <= {vld_pipe[STAGES-1:0], issue};
        lst_pipe <= {lst_pipe[STAGES-1:0], issue & is_last};
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      fifo[wr_ptr]   <= Data;
      last_q[wr_ptr] <= lst_pipe[STAGES];
    end
  end
endmodule

// File: tb/tb_instr_prefetch.sv
// Randomized and directed bench for instr_prefetch against an occupancy /
// scoreboard model of the fetch stream.
module tb_instr_prefetch;
  localparam int DW = 32, AW = 4, DEPTH = 4;

  logic Clk = 0, Rst = 0, Start = 0, Flush = 0, Instr_Ready = 0;
  logic RW, En, Instr_Valid, Instr_Last, Busy, Done;
  logic [AW:0]    Prog_Len = '0;
  logic [AW-1:0]  Addr;
  logic [DW-1:0]  Data = '0, Instr;
  logic [DW-1:0]  mem [16];
  int errors = 0, checks = 0;

  instr_prefetch #(.D_WIDTH(DW), .SA_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Prog_Len(Prog_Len), .Flush(Flush),
    .Addr(Addr), .RW(RW), .En(En), .Data(Data), .Instr(Instr),
    .Instr_Valid(Instr_Valid), .Instr_Ready(Instr_Ready), .Instr_Last(Instr_Last),
    .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  // synchronous program memory: one cycle read latency
  always @(posedge Clk) if (En) Data <= mem[Addr];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill_plan();
    for (int i = 0; i < 16; i++) mem[i] = 32'h2000_0000 + i;
  endtask

  // mode 0: ready high, 1: ready low 10 cycles, 2: random ready, 3: ready high + Start re-pulse
  task automatic run_prog(input int len, input int mode);
    int exp_addr = 0, popped = 0, dones = 0, occ = 0, cyc = 0;
    bit en1 = 0, en2 = 0, ppop = 0, phold = 0, rdy = 0, fin = 0;
    logic [DW-1:0] pinstr = '0;
    @(negedge Clk);
    Start = 1; Prog_Len = len[AW:0]; Instr_Ready = (mode != 1);
    @(negedge Clk);
    Start = 0;
    chk("first_en", En, 1);
    chk("first_addr", Addr, 0);
    while (!fin) begin
      occ += int'(en2) - int'(ppop);
      chk("overflow", occ <= DEPTH, 1);
      chk("valid", Instr_Valid, occ > 0);
      chk("rw", RW, 0);
      if (phold) chk("hold", Instr, pinstr);
      if (mode == 0 && cyc < len) chk("en_run", En, 1);
      if (En) begin
        chk("addr", Addr, exp_addr);
        exp_addr++;
      end
      if (mode == 1 && cyc == 10) begin
        chk("buffered", occ, DEPTH);
        chk("en_stall", En, 0);
      end
      case (mode)
        0, 3:    rdy = 1;
        1:       rdy = (cyc >= 10);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      Instr_Ready = rdy;
      Start = (mode == 3 && (cyc == 3 || cyc == 6));
      if (Start) Prog_Len = 2;
      chk("last", Instr_Last, Instr_Valid && popped == len - 1);
      if (Instr_Valid && rdy) begin
        chk("instr", Instr, mem[popped]);
        popped++;
      end
      if (Done) begin
        dones++;
        chk("busy_in_done", Busy, 1);
        chk("popped_at_done", popped, len);
      end else if (dones > 0) begin
        chk("busy_after_done", Busy, 0);
        fin = 1;
      end
      en2 = en1; en1 = En;
      ppop = Instr_Valid & rdy; phold = Instr_Valid & !rdy; pinstr = Instr;
      cyc++;
      if (cyc > 400) begin
        chk("timeout", 0, 1);
        fin = 1;
      end
      if (!fin) @(negedge Clk);
    end
    Start = 0;
    chk("addr_total", exp_addr, len);
    chk("pop_total", popped, len);
    chk("done_once", dones, 1);
  endtask

  initial begin
    fill_plan();
    #3 chk("reset_out", {Addr, En, RW, Instr_Valid, Instr_Last, Busy, Done}, 0);
    @(negedge Clk) Rst = 1;

    run_prog(9, 0);
    run_prog(9, 1);

    // zero-length program
    @(negedge Clk); Start = 1; Prog_Len = 0;
    @(negedge Clk); Start = 0;
    chk("zero_done", Done, 1);
    chk("zero_busy", {Busy, En, Instr_Valid}, 0);
    repeat (3) begin
      @(negedge Clk);
      chk("zero_quiet", {Done, Busy, En, Instr_Valid}, 0);
    end

    // flush one cycle after the third read strobe
    begin
      int ens = 0, guard = 0;
      @(negedge Clk); Start = 1; Prog_Len = 9; Instr_Ready = 0;
      @(negedge Clk); Start = 0;
      while (ens < 3 && guard < 50) begin
        if (En) ens++;
        if (ens < 3) @(negedge Clk);
        guard++;
      end
      chk("flush_ens", ens, 3);
      @(negedge Clk); Flush = 1;
      @(negedge Clk); Flush = 0;
      chk("flush_next", {Instr_Valid, En, Busy, Done}, 0);
      repeat (6) begin
        @(negedge Clk);
        chk("flush_quiet", {Done, Instr_Valid, En, Busy}, 0);
      end
    end
    run_prog(9, 0);

    // asynchronous reset between edges mid-stream
    @(negedge Clk); Start = 1; Prog_Len = 9; Instr_Ready = 1;
    @(negedge Clk); Start = 0;
    repeat (4) @(negedge Clk);
    #2 Rst = 0;
    #1 chk("rst_async", {Addr, En, Instr_Valid, Instr_Last, Busy, Done}, 0);
    @(negedge Clk) Rst = 1;
    repeat (4) begin
      @(negedge Clk);
      chk("rst_idle", {Instr_Valid, En, Busy, Done}, 0);
    end

    run_prog(9, 3);

    // Start and Flush together: Flush wins
    @(negedge Clk); Start = 1; Flush = 1; Prog_Len = 9;
    @(negedge Clk); Start = 0; Flush = 0;
    repeat (4) begin
      chk("start_flush", {En, Busy, Done, Instr_Valid}, 0);
      @(negedge Clk);
    end

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      run_prog($urandom_range(1, 16), 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/instr_prefetch.md
Name: instr_prefetch

Overview:
- Instruction fetch stage directly upstream of the GPP core.
- Streams instruction words from the synchronous program memory into a small FIFO.
- Presents the words to the core over a valid/ready handshake, so fetch is decoupled from execute.
- Flags the final word and pulses Done when the program is fully delivered.

Parameters:
D_WIDTH, 32, instruction/data word width
SA_WIDTH, 4, program memory address width
DEPTH, 4, FIFO entries (power of 2, >=2)

Ports:
Clk  input  1  clock, all state on rising edge
Rst  input  1  reset, asynchronous, active-low
Start  input  1  one-cycle pulse; begin fetching at address 0
Prog_Len  input  SA_WIDTH+1  number of words to fetch; sampled on accepted Start
Flush  input  1  one-cycle pulse; abort and discard all buffered/in-flight words
Addr  output  SA_WIDTH  memory read address
RW  output  1  memory read/write select, constant 0 (read)
En  output  1  memory read strobe
Data  input  D_WIDTH  memory read data, valid the cycle after En
Instr  output  D_WIDTH  FIFO head word
Instr_Valid  output  1  Instr holds a valid word
Instr_Ready  input  1  core accepts Instr this cycle
Instr_Last  output  1  Instr is the final program word (qualified by Instr_Valid)
Busy  output  1  high from accepted Start until Done
Done  output  1  one-cycle pulse after the last word is popped

Behaviour:
- Reset (Rst=0, async): state IDLE; Addr=0, RW=0, En=0, Instr_Valid=0, Instr_Last=0, Busy=0, Done=0; FIFO pointers, count, fetch counter and in-flight flag cleared. Instr value is don't-care. Any operation in progress is lost.
- All outputs are registered except Instr/Instr_Valid/Instr_Last, which decode the FIFO head.
- FSM states:
  - IDLE: Start=1 -> latch Prog_Len into remaining-count. If Prog_Len=0, pulse Done next cycle and stay IDLE (Busy stays 0, no reads). Otherwise go FETCH.
  - FETCH: issue a read (En=1, Addr=fetch counter) when occupancy + in-flight < DEPTH. Increment the fetch counter on each issue. After issuing word Prog_Len-1, go DRAIN.
  - DRAIN: no reads. When the FIFO is empty, nothing is in flight and the last pop has occurred: assert Done for one cycle, go IDLE.
- Start is ignored while Busy=1.
- Memory latency: Data sampled on the edge one cycle after the En cycle, and pushed into the FIFO on that edge.
- Start latency: Start sampled at edge E0 -> En=1, Addr=0 after E0 -> word pushed at E2 -> Instr_Valid=1 after E2.
- Throughput: with Instr_Ready held high, one word per cycle.
- Handshake:
  - Pop occurs on a cycle with Instr_Valid & Instr_Ready.
  - Instr must stay stable while Valid=1 and Ready=0.
  - Simultaneous push and pop leaves the count unchanged.
  - A push never occurs when full (guaranteed by the issue credit). The bench must assert no overflow.
- Pointers wrap modulo DEPTH. Count ranges 0..DEPTH.
- Instr_Last: each FIFO entry carries a last bit, set on the push of word Prog_Len-1.
- Addr holds its last value when En=0, and never exceeds Prog_Len-1.
- Flush (any state):
  - Next cycle: FIFO emptied, in-flight read discarded (its Data is not pushed), En=0, state IDLE, Busy=0, no Done pulse.
  - Flush has priority over Start in the same cycle.
- Busy=1 from the cycle after an accepted Start (Prog_Len>0) through the Done cycle inclusive.

Test Plan:
- Prog_Len=9, memory word i = 0x20000000+i, Instr_Ready=1 -> Addr 0..8 on consecutive cycles. Instr sequence 0x20000000..0x20000008 is delivered one per cycle. Instr_Last is high only on 0x20000008. Done is a single pulse. Busy falls with Done.
- Prog_Len=9, Instr_Ready=0 for 10 cycles then 1 -> exactly 4 words buffered. En stops while occupancy+in-flight=4, with no overflow. Instr is held stable at 0x20000000. All 9 words are delivered in order after release.
- Start with Prog_Len=0 -> En never asserted, Done pulses one cycle after Start, Busy stays 0, Instr_Valid stays 0.
- Flush one cycle after the 3rd En -> in-flight word discarded, Instr_Valid=0 the next cycle, no Done. A new Start restarts at Addr=0.
- Rst low mid-stream (asynchronous, between edges) -> all outputs take reset values immediately. After release, no Instr_Valid until a new Start.
- Start re-pulsed while Busy, and Start+Flush together -> the re-pulse is ignored and the address sequence is unchanged. Start+Flush together leaves the block IDLE with no reads issued.
